// File: rtl/signed_seq_multiplier.sv
// Signed sequential multiplier: sign-magnitude conversion, WIDTH-step shift-add, conditional negate (optional ovf under MUL_OVF_EN).
// Latency: out_valid rises WIDTH+1 clocks after the accepting edge; best-case throughput one product per WIDTH+3 clocks.
// Backpressure: in_ready only in IDLE; product and out_valid held in DONE until out_ready, no combinational in->out paths.
module signed_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
`ifdef MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 out_valid_q, out_valid_d;
`ifdef MUL_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  // Partial-product add into the upper accumulator half; the carry becomes the new MSB after the shift.
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   prod_s;
  assign sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q & {WIDTH{mag_b_q[0]}}};
  // Magnitude result restored to signed; ~0+1 truncates to 0 so there is no negative zero.
  assign prod_s = neg_q ? (~acc_q + 1'b1) : acc_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;
`ifdef MUL_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Next-state and datapath update for the IDLE -> RUN -> SIGN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
`ifdef MUL_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // -2^(W-1) maps to 2^(W-1), which still fits the unsigned magnitude register.
          mag_a_d = a[WIDTH-1] ? (~a + 1'b1) : a;
          mag_b_d = b[WIDTH-1] ? (~b + 1'b1) : b;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Shift {carry, acc, mag_b} right by one; the low acc bit drops into the consumed multiplier bits.
        acc_d   = {sum_s, acc_q[WIDTH-1:1]};
        mag_b_d = {acc_q[0], mag_b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        p_d         = prod_s;
        out_valid_d = 1'b1;
`ifdef MUL_OVF_EN
        // Out of WIDTH-bit signed range when the top W+1 product bits are not all copies of the sign.
        ovf_d       = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
`endif
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef MUL_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MUL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
`ifdef MUL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed bench for signed_seq_multiplier: products, latency, hold under backpressure, reset abort.
// Expected products are hand-computed constants.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_signed_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
`ifdef MUL_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  signed_seq_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
`ifdef MUL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands on a falling edge, let the next rising edge accept them, then scramble the inputs.
  task automatic accept_now(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h5A;
  endtask

  // Called at the falling edge right after the accepting edge; counts rising edges until out_valid.
  task automatic wait_done(input string tag, input logic [15:0] exp_p, input logic exp_ovf);
    int lat;
    lat = 0;
    check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 32'd9);
    check({tag, "_p"}, {16'd0, p}, {16'd0, exp_p});
`ifdef MUL_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 32'd0, 32'd1);
`endif
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_rdy_back"}, {31'd0, in_ready}, 32'd1);
`ifdef MUL_OVF_EN
    check({tag, "_ovf_clr"}, {31'd0, ovf}, 32'd0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'd0;
    b         = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_p", {16'd0, p}, 32'd0);
`ifdef MUL_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // 3 * 5
    accept_now(8'd3, 8'd5);
    wait_done("m3x5", 16'h000F, 1'b0);
    handoff("m3x5");

    // -7 * 6 = -42
    accept_now(8'hF9, 8'd6);
    wait_done("mn7x6", 16'hFFD6, 1'b0);
    handoff("mn7x6");

    // -128 * -128 = 16384
    accept_now(8'h80, 8'h80);
    wait_done("mn128sq", 16'h4000, 1'b1);
    handoff("mn128sq");

    // -128 * 127 = -16256
    accept_now(8'h80, 8'h7F);
    wait_done("mn128x127", 16'hC080, 1'b1);
    handoff("mn128x127");

    // 0 * -1 : no negative zero
    accept_now(8'h00, 8'hFF);
    wait_done("m0xn1", 16'h0000, 1'b0);
    handoff("m0xn1");

    // -1 * -1
    accept_now(8'hFF, 8'hFF);
    wait_done("mn1xn1", 16'h0001, 1'b0);
    handoff("mn1xn1");

    // 7 * 9 with the consumer stalled for 5 clocks
    accept_now(8'd7, 8'd9);
    wait_done("m7x9", 16'h003F, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_vld", {31'd0, out_valid}, 32'd1);
      check("hold_p", {16'd0, p}, 32'h003F);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    handoff("m7x9");

    // out_ready and in_valid together in DONE: handoff only, operands taken one clock later
    accept_now(8'd10, 8'd10);
    wait_done("m10x10", 16'h0064, 1'b0);
    a         = 8'd2;
    b         = 8'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("sim_no_accept_rdy", {31'd0, in_ready}, 32'd1);
    check("sim_vld_clr", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h5A;
    wait_done("m2x2", 16'h0004, 1'b0);
    handoff("m2x2");

    // Reset pulsed during RUN aborts the operation
    accept_now(8'd5, 8'd5);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_p", {16'd0, p}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_result", {31'd0, out_valid}, 32'd0);

    // 2 * -3 after the abort
    accept_now(8'd2, 8'hFD);
    wait_done("m2xn3", 16'hFFFA, 1'b0);
    handoff("m2xn3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
